// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Consumer-side companion to the system PLL. It drives the PLL reset, watches
// the (asynchronous) PLL locked flag and holds the game core in reset until
// lock has been stable for STABLE_CYCLES. While running, it produces
// single-cycle clock-enables at clk_sys/8, /16, /32 and /64
// (12, 6, 3 and 1.5 MHz from 96 MHz).
//
// Ports:
//   clk_sys_i     system clock (96 MHz PLL output)
//   reset_i       synchronous active-high reset, overrides everything
//   pll_locked_i  PLL locked flag, asynchronous to clk_sys_i
//   pll_rst_o     reset request to the PLL
//   core_reset_o  synchronous active-high reset to the game core
//   cen_12_o      one-cycle enable every 8th clk_sys cycle (RUN only)
//   cen_6_o       one-cycle enable every 16th clk_sys cycle (RUN only)
//   cen_3_o       one-cycle enable every 32nd clk_sys cycle (RUN only)
//   cen_1p5_o     one-cycle enable every 64th clk_sys cycle (RUN only)
//   lost_lock_o   sticky: lock dropped while in RUN
//   retries_o     PLL reset attempts after the first, saturating at 15
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk_sys_i,
    input  logic       reset_i,
    input  logic       pll_locked_i,
    output logic       pll_rst_o,
    output logic       core_reset_o,
    output logic       cen_12_o,
    output logic       cen_6_o,
    output logic       cen_3_o,
    output logic       cen_1p5_o,
    output logic       lost_lock_o,
    output logic [3:0] retries_o
);

    // One shared phase counter serves all three timed states; it is sized
    // for the longest of them.
    localparam int MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_B = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_B + 1);

    localparam logic [1:0] ST_PLL_RST   = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [1:0]             state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic [5:0]             div_q,       div_d;
    logic                   pll_rst_q,   pll_rst_d;
    logic                   core_reset_q, core_reset_d;
    logic                   cen_12_q,    cen_12_d;
    logic                   cen_6_q,     cen_6_d;
    logic                   cen_3_q,     cen_3_d;
    logic                   cen_1p5_q,   cen_1p5_d;
    logic                   lost_lock_q, lost_lock_d;
    logic [3:0]             retries_q,   retries_d;
    logic                   lk_s;
    logic                   run_stay_s;

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Lock synchronizer. It is flushed while the PLL is held in reset so that
    // a stale lock from before the reset pulse is never counted: every lock
    // seen in WAIT_LOCK has travelled the full synchronizer depth.
    always_comb begin
        if (state_q == ST_PLL_RST) begin
            sync_d = {SYNC_STAGES{1'b0}};
        end else begin
            sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    // Sequencer next-state, phase counter, sticky lost_lock and retry count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lost_lock_d = lost_lock_q;
        retries_d   = retries_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lk_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = {CNT_W{1'b0}};
                    if (retries_q != 4'hF) begin
                        retries_d = retries_q + 4'd1;
                    end else begin
                        retries_d = retries_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = {CNT_W{1'b0}};
                    lost_lock_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered outputs are decoded from the next state so that they change
    // on the same edge as the state itself.
    always_comb begin
        pll_rst_d    = (state_d == ST_PLL_RST);
        core_reset_d = (state_d != ST_RUN);
    end

    // Divider and clock-enables. Pulses only fire when RUN is both current
    // and next, so leaving RUN never produces a partial pulse.
    always_comb begin
        run_stay_s = (state_q == ST_RUN) && (state_d == ST_RUN);
        if (run_stay_s) begin
            div_d = div_q + 6'd1;
        end else begin
            div_d = 6'd0;
        end
        cen_12_d  = run_stay_s && (div_q[2:0] == 3'd7);
        cen_6_d   = run_stay_s && (div_q[3:0] == 4'd15);
        cen_3_d   = run_stay_s && (div_q[4:0] == 5'd31);
        cen_1p5_d = run_stay_s && (div_q == 6'd63);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= {CNT_W{1'b0}};
            sync_q       <= {SYNC_STAGES{1'b0}};
            div_q        <= 6'd0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            cen_12_q     <= 1'b0;
            cen_6_q      <= 1'b0;
            cen_3_q      <= 1'b0;
            cen_1p5_q    <= 1'b0;
            lost_lock_q  <= 1'b0;
            retries_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            div_q        <= div_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            cen_12_q     <= cen_12_d;
            cen_6_q      <= cen_6_d;
            cen_3_q      <= cen_3_d;
            cen_1p5_q    <= cen_1p5_d;
            lost_lock_q  <= lost_lock_d;
            retries_q    <= retries_d;
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign core_reset_o = core_reset_q;
    assign cen_12_o     = cen_12_q;
    assign cen_6_o      = cen_6_q;
    assign cen_3_o      = cen_3_q;
    assign cen_1p5_o    = cen_1p5_q;
    assign lost_lock_o  = lost_lock_q;
    assign retries_o    = retries_q;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumer-side companion to the system PLL. It drives the PLL reset and watches the PLL locked signal.
- Holds the core in reset until lock has been stable for a programmable time, then generates the core clock-enables from clk_sys (96 MHz) as single-cycle pulses: 12, 6, 3 and 1.5 MHz.
- Re-pulses the PLL reset if lock never arrives, and re-asserts core reset if lock is lost.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous pll_locked input (minimum 2).
- PLL_RST_CYCLES, 16, clk_sys cycles that pll_rst is held high per attempt.
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before releasing core reset.
- TIMEOUT_CYCLES, 1048576, cycles in WAIT_LOCK without lock before a PLL reset retry.

Ports:
- clk_sys  in  1  system clock, 96 MHz PLL output.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked, asynchronous to clk_sys.
- pll_rst  out  1  reset request to the PLL.
- core_reset  out  1  synchronous active-high reset to the game core.
- cen_12  out  1  one-cycle enable, every 8th clk_sys.
- cen_6  out  1  one-cycle enable, every 16th clk_sys.
- cen_3  out  1  one-cycle enable, every 32nd clk_sys.
- cen_1p5  out  1  one-cycle enable, every 64th clk_sys.
- lost_lock  out  1  sticky: lock dropped while in RUN.
- retries  out  4  PLL reset attempts after the first; saturates at 15.

Behaviour:
- Clocking and reset:
  - One clock, clk_sys. All state is updated on its rising edge.
  - reset is synchronous, active-high, and overrides everything else.
- Reset values:
  - state = PLL_RST, pll_rst = 1, core_reset = 1.
  - All cen_* = 0, divider = 0, lost_lock = 0, retries = 0.
  - Synchronizer flops = 0; phase and timeout counters = 0.
- Synchronizer: pll_locked passes through SYNC_STAGES flops to give lk_s. Only lk_s is used internally.
- States:
  - PLL_RST:
    - pll_rst = 1, core_reset = 1.
    - Counts PLL_RST_CYCLES cycles including the entry cycle, then goes to WAIT_LOCK.
  - WAIT_LOCK:
    - pll_rst = 0, core_reset = 1, timeout counter runs.
    - If lk_s = 1, go to STABLE with the stable counter at 0.
    - Else, when the timeout counter reaches TIMEOUT_CYCLES-1, go to PLL_RST and do retries += 1 (saturating).
    - If lk_s rises on the timeout cycle, lk_s wins.
  - STABLE:
    - core_reset = 1; stable counter increments while lk_s = 1.
    - Any lk_s = 0 returns to WAIT_LOCK and clears the timeout counter.
    - When the count reaches STABLE_CYCLES-1 with lk_s = 1, go to RUN.
  - RUN:
    - core_reset = 0; the 6-bit divider increments every cycle.
    - If lk_s = 0: next state WAIT_LOCK, lost_lock set to 1, and core_reset = 1 from the following cycle.
- Latency:
  - Let T be the first edge sampling pll_locked = 1 in WAIT_LOCK.
  - core_reset is low from edge T + SYNC_STAGES + STABLE_CYCLES onward.
- Clock-enables:
  - Registered outputs, asserted only in RUN. The divider is cleared in every other state.
  - cen_12 = 1 in the cycle after div[2:0] == 7.
  - cen_6 = 1 in the cycle after div[3:0] == 15.
  - cen_3 = 1 in the cycle after div[4:0] == 31.
  - cen_1p5 = 1 in the cycle after div == 63.
  - Coincident pulses are expected (e.g. all four together every 64 cycles).
  - The divider wraps 63 -> 0 without a gap.
  - The first cen_12 occurs 8 cycles after core_reset falls.
  - Leaving RUN forces all cen_* to 0 on the next edge. No partial pulse is emitted.
- Sticky and saturating flags:
  - lost_lock is cleared only by reset.
  - retries is cleared only by reset; 15 + 1 stays at 15.
- Reset mid-operation: asserting reset in any state returns to PLL_RST with reset values on the next edge, and pll_rst is reasserted immediately.

Test Plan (bench parameters: PLL_RST_CYCLES = 4, STABLE_CYCLES = 16, TIMEOUT_CYCLES = 64):
1. Reset then release with pll_locked = 1 from start:
   - pll_rst high for 4 cycles.
   - core_reset falls exactly SYNC_STAGES + 16 cycles after lock is first sampled in WAIT_LOCK.
   - cen_12 first pulses 8 cycles after that.
2. Free run for 256 cycles in RUN:
   - cen_12 = 32, cen_6 = 16, cen_3 = 8, cen_1p5 = 4 pulses, each exactly 1 cycle wide.
   - All four coincide every 64 cycles.
3. pll_locked held 0:
   - pll_rst re-pulses (4 cycles) every 64 + 4 cycles.
   - retries counts 1, 2, ... and saturates at 15 after 16 timeouts.
   - core_reset stays 1.
4. pll_locked glitch low for 1 cycle at stable count 10 → state returns to WAIT_LOCK; core_reset falls only after a full 16 stable cycles following recovery.
5. pll_locked drops in RUN:
   - core_reset = 1 within SYNC_STAGES + 2 cycles.
   - cen_* stop with no partial pulse; lost_lock = 1 and stays set after re-lock.
6. reset asserted in RUN → next edge: pll_rst = 1, core_reset = 1, lost_lock = 0, retries = 0, all cen_* = 0.
